// File: rtl/trace_emitter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : trace_pkg
//  Brief    : Shared types and constants for the retire-trace transmitter:
//             record type codes, header words, stat-word index, serializer
//             state encoding, event-queue entry layout and small helpers.
//  Revision : 1.0  initial release
// ============================================================================
package trace_pkg;

    localparam logic [3:0]  c_TYPE_REG   = 4'h1;
    localparam logic [3:0]  c_TYPE_LOAD  = 4'h2;
    localparam logic [3:0]  c_TYPE_STORE = 4'h3;
    localparam logic [3:0]  c_TYPE_HALT  = 4'hF;
    localparam logic [15:0] c_HDR_LOAD   = {c_TYPE_LOAD,  12'h000};
    localparam logic [15:0] c_HDR_STORE  = {c_TYPE_STORE, 12'h000};

    // Order of the eight statistics words following the HALT header.
    typedef enum logic [2:0] {
        STAT_CYC_HI  = 3'd0,
        STAT_CYC_LO  = 3'd1,
        STAT_INST_HI = 3'd2,
        STAT_INST_LO = 3'd3,
        STAT_DC_HIT  = 3'd4,
        STAT_IC_HIT  = 3'd5,
        STAT_DC_REQ  = 3'd6,
        STAT_IC_REQ  = 3'd7
    } stat_idx_t;

    // Each state names the word currently offered on the stream.
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_REG_HDR  = 4'd1,
        ST_REG_DAT  = 4'd2,
        ST_MEM_HDR  = 4'd3,
        ST_MEM_ADDR = 4'd4,
        ST_MEM_DAT  = 4'd5,
        ST_HALT_HDR = 4'd6,
        ST_STAT     = 4'd7,
        ST_DONE     = 4'd8
    } state_t;

    // One retiring event; memData already holds the store or load value.
    typedef struct packed {
        logic        isReg;
        logic        isLoad;
        logic        isStore;
        logic        isHalt;
        logic [3:0]  writeReg;
        logic [15:0] writeData;
        logic [15:0] memAddr;
        logic [15:0] memData;
    } evq_entry_t;

    // First word of an entry: REG before LOAD/STORE before HALT.
    function automatic state_t firstState(input evq_entry_t e);
        state_t s;
        s = ST_IDLE;
        if (e.isReg)                   s = ST_REG_HDR;
        else if (e.isLoad | e.isStore) s = ST_MEM_HDR;
        else if (e.isHalt)             s = ST_HALT_HDR;
        return s;
    endfunction

    function automatic logic [15:0] satInc16(input logic [15:0] v, input logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/trace_emitter_if.sv
`default_nettype none
// ============================================================================
//  Module   : trace_emitter_if
//  Brief    : Valid/ready trace-word stream between emitter and consumer.
//  Revision : 1.0  initial release
// ============================================================================
interface trace_emitter_if;
    logic        tr_valid;
    logic        tr_ready;
    logic [15:0] tr_data;
    logic        tr_last;

    modport master (output tr_valid, output tr_data, output tr_last, input tr_ready);
    modport slave  (input tr_valid, input tr_data, input tr_last, output tr_ready);
endinterface
`default_nettype wire

// File: rtl/trace_emitter_evq.sv
`default_nettype none
// ============================================================================
//  Module   : trace_evq
//  Brief    : Synchronous FIFO of retiring events with occupancy count;
//             push and pop may occur in the same cycle. The caller never
//             pushes when full nor pops when empty.
//  Revision : 1.0  initial release
// ============================================================================
module trace_evq
    import trace_pkg::*;
#(
    parameter int DEPTH = 8
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  evq_entry_t               pushData,
    input  logic                     pop,
    output evq_entry_t               popData,
    output logic [$clog2(DEPTH):0]   cnt,
    output logic                     empty
);
    localparam int c_AW = $clog2(DEPTH);

    evq_entry_t         r_mem [DEPTH];
    logic [c_AW-1:0]    r_wrPtr;
    logic [c_AW-1:0]    r_rdPtr;
    logic [c_AW:0]      r_cnt;

    // Storage array; contents need no reset since r_cnt gates visibility.
    always_ff @(posedge clk) begin
        if (push) r_mem[r_wrPtr] <= pushData;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_cnt   <= '0;
        end else begin
            if (push) r_wrPtr <= r_wrPtr + 1'b1;
            if (pop)  r_rdPtr <= r_rdPtr + 1'b1;
            if (push && !pop)      r_cnt <= r_cnt + 1'b1;
            else if (pop && !push) r_cnt <= r_cnt - 1'b1;
        end
    end

    assign popData = r_mem[r_rdPtr];
    assign cnt     = r_cnt;
    assign empty   = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/trace_emitter.sv
`default_nettype none
// ============================================================================
//  Module   : trace_emitter
//  Brief    : Captures retiring writeback/memory events into a queue and
//             serializes them as 16-bit trace records; on halt it appends a
//             statistics record and then goes quiet until reset.
//  Revision : 1.0  initial release
// ============================================================================
module trace_emitter
    import trace_pkg::*;
#(
    parameter int EVQ_DEPTH = 8
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    reg_write,
    input  logic [3:0]              write_reg,
    input  logic [15:0]             write_data,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic [15:0]             mem_addr,
    input  logic [15:0]             mem_wdata,
    input  logic [15:0]             mem_rdata,
    input  logic                    halt,
    input  logic                    icache_req,
    input  logic                    icache_hit,
    input  logic                    dcache_req,
    input  logic                    dcache_hit,
    trace_emitter_if.master         tr,
    output logic                    overflow,
    output logic                    done
);
    localparam int              c_CW       = $clog2(EVQ_DEPTH);
    localparam logic [c_CW:0]   c_DEPTH    = (c_CW+1)'(EVQ_DEPTH);
    localparam logic [c_CW:0]   c_DEPTH_M1 = (c_CW+1)'(EVQ_DEPTH - 1);

    logic [31:0] r_cycleCnt, r_instCnt;
    logic [15:0] r_icReq, r_icHit, r_dcReq, r_dcHit;
    logic [7:0]  r_dropCnt;
    logic        r_frozen, r_overflow;
    state_t      r_state, w_cur, w_after, w_stateNext;
    stat_idx_t   r_statIdx, w_idxNext;

    logic [c_CW:0] w_cnt;
    logic          w_empty, w_event, w_room, w_push, w_drop, w_pop;
    logic          w_valid, w_last, w_entryEnd, w_xfer;
    logic [15:0]   w_data, w_statWord;
    evq_entry_t    w_pushEntry, w_head;

    trace_evq #(.DEPTH(EVQ_DEPTH)) u_evq (
        .clk      (clk),
        .rst      (rst),
        .push     (w_push),
        .pushData (w_pushEntry),
        .pop      (w_pop),
        .popData  (w_head),
        .cnt      (w_cnt),
        .empty    (w_empty)
    );

    // Capture decision: one slot is held back so a halt always finds room.
    always_comb begin
        w_event = (reg_write | mem_read | mem_write | halt) & ~r_frozen;
        w_room  = halt ? (w_cnt < c_DEPTH) : (w_cnt < c_DEPTH_M1);
        w_push  = w_event & w_room;
        w_drop  = w_event & ~w_room;
        w_pushEntry.isReg     = reg_write;
        w_pushEntry.isStore   = mem_write;
        w_pushEntry.isLoad    = mem_read & ~mem_write;
        w_pushEntry.isHalt    = halt;
        w_pushEntry.writeReg  = write_reg;
        w_pushEntry.writeData = write_data;
        w_pushEntry.memAddr   = mem_addr;
        w_pushEntry.memData   = mem_write ? mem_wdata : mem_rdata;
    end

    // Statistics and drop bookkeeping; halt-cycle counts are kept, then frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycleCnt <= '0;
            r_instCnt  <= '0;
            r_icReq    <= '0;
            r_icHit    <= '0;
            r_dcReq    <= '0;
            r_dcHit    <= '0;
            r_dropCnt  <= '0;
            r_frozen   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
                r_dropCnt  <= r_dropCnt + 8'd1;
            end
            if (!r_frozen) begin
                r_cycleCnt <= r_cycleCnt + 32'd1;
                if (halt | reg_write | mem_write) r_instCnt <= r_instCnt + 32'd1;
                r_icReq <= satInc16(r_icReq, icache_req);
                r_icHit <= satInc16(r_icHit, icache_hit);
                r_dcReq <= satInc16(r_dcReq, dcache_req);
                r_dcHit <= satInc16(r_dcHit, dcache_hit);
                if (w_push && halt) r_frozen <= 1'b1;
            end
        end
    end

    // Statistics word selected by the current STAT index.
    always_comb begin
        w_statWord = '0;
        case (r_statIdx)
            STAT_CYC_HI:  w_statWord = r_cycleCnt[31:16];
            STAT_CYC_LO:  w_statWord = r_cycleCnt[15:0];
            STAT_INST_HI: w_statWord = r_instCnt[31:16];
            STAT_INST_LO: w_statWord = r_instCnt[15:0];
            STAT_DC_HIT:  w_statWord = r_dcHit;
            STAT_IC_HIT:  w_statWord = r_icHit;
            STAT_DC_REQ:  w_statWord = r_dcReq;
            STAT_IC_REQ:  w_statWord = r_icReq;
            default:      w_statWord = '0;
        endcase
    end

    // Serializer: IDLE with a non-empty queue already offers the head's first
    // word, so a fresh entry is visible the cycle after capture and records
    // from consecutive entries follow without a gap.
    always_comb begin
        w_cur = r_state;
        if (r_state == ST_IDLE && !w_empty) w_cur = firstState(w_head);
        w_valid    = 1'b0;
        w_data     = '0;
        w_last     = 1'b0;
        w_entryEnd = 1'b0;
        w_after    = w_cur;
        case (w_cur)
            ST_REG_HDR: begin
                w_valid = 1'b1;
                w_data  = {c_TYPE_REG, w_head.writeReg, 8'h00};
                w_after = ST_REG_DAT;
            end
            ST_REG_DAT: begin
                w_valid = 1'b1;
                w_data  = w_head.writeData;
                w_last  = 1'b1;
                if (w_head.isLoad | w_head.isStore) w_after = ST_MEM_HDR;
                else if (w_head.isHalt)             w_after = ST_HALT_HDR;
                else                                w_entryEnd = 1'b1;
            end
            ST_MEM_HDR: begin
                w_valid = 1'b1;
                w_data  = w_head.isStore ? c_HDR_STORE : c_HDR_LOAD;
                w_after = ST_MEM_ADDR;
            end
            ST_MEM_ADDR: begin
                w_valid = 1'b1;
                w_data  = w_head.memAddr;
                w_after = ST_MEM_DAT;
            end
            ST_MEM_DAT: begin
                w_valid = 1'b1;
                w_data  = w_head.memData;
                w_last  = 1'b1;
                if (w_head.isHalt) w_after = ST_HALT_HDR;
                else               w_entryEnd = 1'b1;
            end
            ST_HALT_HDR: begin
                w_valid = 1'b1;
                w_data  = {c_TYPE_HALT, 4'h0, r_dropCnt};
                w_after = ST_STAT;
            end
            ST_STAT: begin
                w_valid    = 1'b1;
                w_data     = w_statWord;
                w_last     = (r_statIdx == STAT_IC_REQ);
                w_entryEnd = (r_statIdx == STAT_IC_REQ);
            end
            default: ;
        endcase
        w_xfer      = w_valid & tr.tr_ready;
        w_pop       = w_xfer & w_entryEnd;
        w_stateNext = w_cur;
        w_idxNext   = r_statIdx;
        if (w_xfer) begin
            if (w_entryEnd) begin
                w_stateNext = w_head.isHalt ? ST_DONE : ST_IDLE;
                w_idxNext   = STAT_CYC_HI;
            end else begin
                w_stateNext = w_after;
                if (w_cur == ST_STAT) w_idxNext = stat_idx_t'(r_statIdx + 3'd1);
            end
        end
    end

    // Serializer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_statIdx <= STAT_CYC_HI;
        end else begin
            r_state   <= w_stateNext;
            r_statIdx <= w_idxNext;
        end
    end

    assign tr.tr_valid = w_valid;
    assign tr.tr_data  = w_data;
    assign tr.tr_last  = w_last;
    assign overflow    = r_overflow;
    assign done        = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_trace_emitter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_trace_emitter
//  Brief    : Self-checking bench for trace_emitter: directed vector table,
//             hand-written corner sequences and randomized traffic checked
//             against a word-level scoreboard model.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_trace_emitter;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_write, mem_read, mem_write, halt;
    logic [3:0]  write_reg;
    logic [15:0] write_data, mem_addr, mem_wdata, mem_rdata;
    logic        icache_req, icache_hit, dcache_req, dcache_hit;
    logic        overflow, done;

    trace_emitter_if trIf();

    trace_emitter #(.EVQ_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .halt(halt),
        .icache_req(icache_req), .icache_hit(icache_hit),
        .dcache_req(dcache_req), .dcache_hit(dcache_hit),
        .tr(trIf), .overflow(overflow), .done(done)
    );

    always #5 clk = ~clk;

    // Scoreboard: expected words in stream order, tagged with entry boundaries.
    typedef struct { logic [15:0] data; bit last; bit endEntry; bit isFinal; } word_t;
    word_t       expQ[$];
    logic [15:0] seen[$];
    int          mEntries;
    bit          mFrozen, mOverflow, mDone;
    logic [31:0] mCycle, mInst;
    logic [15:0] mIcReq, mIcHit, mDcReq, mDcHit;
    logic [7:0]  mDrops;

    int vectors = 0;
    int miscompares = 0;

    bit          tChk;
    int          tIdx;
    bit          tExpValid;
    logic [15:0] tExpData;
    bit          tExpLast;

    typedef struct {
        bit rw; logic [3:0] wr; logic [15:0] wd;
        bit mr; bit mw; logic [15:0] ma; logic [15:0] mwd; logic [15:0] mrd;
        bit rdy; bit ev; logic [15:0] ed; bit el;
    } vec_t;
    vec_t tbl[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clearInputs();
        reg_write = 0; write_reg = '0; write_data = '0;
        mem_read = 0; mem_write = 0; mem_addr = '0; mem_wdata = '0; mem_rdata = '0;
        halt = 0; icache_req = 0; icache_hit = 0; dcache_req = 0; dcache_hit = 0;
    endtask

    task automatic modelReset();
        expQ.delete(); seen.delete();
        mEntries = 0; mFrozen = 0; mOverflow = 0; mDone = 0;
        mCycle = '0; mInst = '0; mIcReq = '0; mIcHit = '0; mDcReq = '0; mDcHit = '0;
        mDrops = '0;
    endtask

    // Words of one captured event, built from the record format rules.
    task automatic modelCapture();
        logic [15:0] wd[16];
        bit          wl[16];
        logic [15:0] st[8];
        int          n;
        n = 0;
        if (reg_write) begin
            wd[n] = {4'h1, write_reg, 8'h00}; wl[n] = 0; n++;
            wd[n] = write_data;               wl[n] = 1; n++;
        end
        if (mem_write || mem_read) begin
            wd[n] = mem_write ? 16'h3000 : 16'h2000; wl[n] = 0; n++;
            wd[n] = mem_addr;                        wl[n] = 0; n++;
            wd[n] = mem_write ? mem_wdata : mem_rdata; wl[n] = 1; n++;
        end
        if (halt) begin
            st[0] = mCycle[31:16]; st[1] = mCycle[15:0];
            st[2] = mInst[31:16];  st[3] = mInst[15:0];
            st[4] = mDcHit; st[5] = mIcHit; st[6] = mDcReq; st[7] = mIcReq;
            wd[n] = {4'hF, 4'h0, mDrops}; wl[n] = 0; n++;
            for (int i = 0; i < 8; i++) begin
                wd[n] = st[i]; wl[n] = (i == 7); n++;
            end
        end
        for (int i = 0; i < n; i++)
            expQ.push_back('{wd[i], wl[i], (i == n-1), (halt && (i == n-1))});
        mEntries++;
        if (halt) mFrozen = 1;
    endtask

    // One clock cycle: compare at the falling edge, then advance the model.
    task automatic step();
        bit ev, room;
        word_t w;
        @(negedge clk);
        if (rst) begin
            modelReset();
        end else begin
            check("valid", 32'(trIf.tr_valid), 32'(expQ.size() > 0));
            if (expQ.size() > 0) begin
                check("data", 32'(trIf.tr_data), 32'(expQ[0].data));
                check("last", 32'(trIf.tr_last), 32'(expQ[0].last));
            end
            check("overflow", 32'(overflow), 32'(mOverflow));
            check("done", 32'(done), 32'(mDone));
            if (tChk) begin
                check($sformatf("tbl%0d_valid", tIdx), 32'(trIf.tr_valid), 32'(tExpValid));
                if (tExpValid) begin
                    check($sformatf("tbl%0d_data", tIdx), 32'(trIf.tr_data), 32'(tExpData));
                    check($sformatf("tbl%0d_last", tIdx), 32'(trIf.tr_last), 32'(tExpLast));
                end
            end
            ev   = (reg_write | mem_read | mem_write | halt) && !mFrozen;
            room = halt ? (mEntries < DEPTH) : (mEntries < DEPTH - 1);
            if (trIf.tr_valid && trIf.tr_ready) begin
                seen.push_back(trIf.tr_data);
                if (expQ.size() > 0) begin
                    w = expQ.pop_front();
                    if (w.endEntry) mEntries--;
                    if (w.isFinal)  mDone = 1;
                end
            end
            if (!mFrozen) begin
                mCycle++;
                if (halt | reg_write | mem_write) mInst++;
                if (icache_req && mIcReq != 16'hFFFF) mIcReq++;
                if (icache_hit && mIcHit != 16'hFFFF) mIcHit++;
                if (dcache_req && mDcReq != 16'hFFFF) mDcReq++;
                if (dcache_hit && mDcHit != 16'hFFFF) mDcHit++;
            end
            if (ev) begin
                if (room) modelCapture();
                else begin mOverflow = 1; mDrops++; end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic doReset();
        clearInputs();
        trIf.tr_ready = 0;
        rst = 1;
        step();
        @(negedge clk);
        check("rst_valid", 32'(trIf.tr_valid), 32'd0);
        check("rst_data", 32'(trIf.tr_data), 32'd0);
        check("rst_last", 32'(trIf.tr_last), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        modelReset();
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic drain();
        trIf.tr_ready = 1;
        clearInputs();
        for (int i = 0; i < 200 && !done; i++) step();
        check("drain_done", 32'(done), 32'd1);
        step();
    endtask

    initial begin
        logic [15:0] statExp[9];
        int          pct[3];
        tChk = 0;
        tIdx = 0;
        tExpValid = 0; tExpData = '0; tExpLast = 0;

        //            rw wr     wd        mr mw ma        mwd       mrd       rdy ev ed        el
        tbl[0]  = '{1, 4'd3, 16'h1234, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 16'h0000, 0};
        tbl[1]  = '{0, 4'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 1, 16'h1300, 0};
        tbl[2]  = '{0, 4'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 1, 16'h1234, 1};
        tbl[3]  = '{1, 4'd1, 16'h00AA, 0, 1, 16'h0040, 16'hBEEF, 16'h0000, 1, 0, 16'h0000, 0};
        tbl[4]  = '{0, 4'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 1, 16'h1100, 0};
        tbl[5]  = '{0, 4'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 1, 16'h00AA, 1};
        tbl[6]  = '{0, 4'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 1, 16'h3000, 0};
        tbl[7]  = '{0, 4'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 1, 16'h0040, 0};
        tbl[8]  = '{0, 4'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 1, 16'hBEEF, 1};
        tbl[9]  = '{0, 4'd0, 16'h0000, 1, 0, 16'h0080, 16'h0000, 16'h5A5A, 0, 0, 16'h0000, 0};
        tbl[10] = '{0, 4'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 16'h2000, 0};
        tbl[11] = '{0, 4'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 1, 16'h2000, 0};
        tbl[12] = '{0, 4'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 16'h0080, 0};
        tbl[13] = '{0, 4'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 1, 16'h0080, 0};
        tbl[14] = '{0, 4'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 16'h5A5A, 1};
        tbl[15] = '{0, 4'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 1, 16'h5A5A, 1};
        tbl[16] = '{0, 4'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 16'h0000, 0};

        doReset();

        // Directed table: REG, same-cycle REG+STORE, LOAD under backpressure.
        tChk = 1;
        for (int i = 0; i < 17; i++) begin
            clearInputs();
            reg_write = tbl[i].rw; write_reg = tbl[i].wr; write_data = tbl[i].wd;
            mem_read = tbl[i].mr; mem_write = tbl[i].mw; mem_addr = tbl[i].ma;
            mem_wdata = tbl[i].mwd; mem_rdata = tbl[i].mrd;
            trIf.tr_ready = tbl[i].rdy;
            tIdx = i; tExpValid = tbl[i].ev; tExpData = tbl[i].ed; tExpLast = tbl[i].el;
            step();
        end
        tChk = 0;

        // Overflow: stalled consumer, 10 reg writes then halt.
        doReset();
        for (int c = 0; c < 10; c++) begin
            clearInputs();
            reg_write = 1; write_reg = 4'(c); write_data = 16'(16'h0100 + c);
            step();
        end
        clearInputs();
        halt = 1;
        step();
        clearInputs();
        check("ovf_sticky", 32'(overflow), 32'd1);
        drain();
        check("ovf_len", 32'(seen.size()), 32'd23);
        check("ovf_halt_hdr", 32'(seen[14]), 32'h0000F003);

        // Halt statistics: 11 reg writes + halt in cycle 20.
        doReset();
        trIf.tr_ready = 1;
        for (int c = 1; c <= 20; c++) begin
            clearInputs();
            reg_write = (c <= 11); write_reg = 4'(c); write_data = 16'(c * 3);
            dcache_req = (c <= 5); dcache_hit = (c <= 4);
            icache_req = 1; icache_hit = (c <= 15);
            halt = (c == 20);
            step();
        end
        drain();
        statExp[0] = 16'hF000; statExp[1] = 16'h0000; statExp[2] = 16'h0014;
        statExp[3] = 16'h0000; statExp[4] = 16'h000C; statExp[5] = 16'h0004;
        statExp[6] = 16'h000F; statExp[7] = 16'h0005; statExp[8] = 16'h0014;
        check("stat_len", 32'(seen.size()), 32'd31);
        for (int i = 0; i < 9; i++)
            check($sformatf("stat_word%0d", i), 32'(seen[22 + i]), 32'(statExp[i]));

        // Reset in the middle of a STORE record.
        doReset();
        trIf.tr_ready = 1;
        clearInputs();
        mem_write = 1; mem_addr = 16'h0040; mem_wdata = 16'h1111;
        step();
        clearInputs();
        step();
        rst = 1;
        @(negedge clk);
        check("rstmid_addr_word", 32'(trIf.tr_data), 32'h00000040);
        modelReset();
        @(posedge clk); #1;
        rst = 0;
        check("rstmid_valid", 32'(trIf.tr_valid), 32'd0);
        reg_write = 1; write_reg = 4'd5; write_data = 16'h0055;
        step();
        clearInputs();
        for (int i = 0; i < 4; i++) step();
        check("rstmid_len", 32'(seen.size()), 32'd2);
        check("rstmid_hdr", 32'(seen[0]), 32'h00001500);
        check("rstmid_dat", 32'(seen[1]), 32'h00000055);

        // Randomized traffic at three consumer rates, halt late in each run.
        pct[0] = 90; pct[1] = 50; pct[2] = 20;
        for (int r = 0; r < 3; r++) begin
            doReset();
            for (int c = 0; c < 400; c++) begin
                reg_write  = ($urandom_range(0, 99) < 35);
                write_reg  = 4'($urandom);
                write_data = 16'($urandom);
                mem_read   = ($urandom_range(0, 99) < 20);
                mem_write  = ($urandom_range(0, 99) < 15);
                mem_addr   = 16'($urandom);
                mem_wdata  = 16'($urandom);
                mem_rdata  = 16'($urandom);
                halt       = (c == 350);
                icache_req = 1'($urandom); icache_hit = 1'($urandom);
                dcache_req = 1'($urandom); dcache_hit = 1'($urandom);
                trIf.tr_ready = ($urandom_range(0, 99) < pct[r]);
                step();
            end
            drain();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/trace_emitter.md
# trace_emitter

Synthesizable retire-trace transmitter inside `cpu`. Each cycle it samples the writeback and memory-stage commit signals plus the cache request and hit strobes. It queues every retiring event and serializes it as 16-bit trace records on a valid/ready stream. On halt it appends a statistics record (cycles, instructions, cache requests and hits) and then goes quiet, giving a bench or host link the same information as the simulation trace and log without hierarchical probing.

## Interface
- `EVQ_DEPTH`, default 8: event-queue entries; power of two, ≥2.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `reg_write`  in  1  register file written this cycle.
- `write_reg`  in  4  destination register.
- `write_data`  in  16  register write value.
- `mem_read`  in  1  load in memory stage.
- `mem_write`  in  1  store in memory stage.
- `mem_addr`  in  16  memory address.
- `mem_wdata`  in  16  store data.
- `mem_rdata`  in  16  load data.
- `halt`  in  1  halt retiring.
- `icache_req`, `icache_hit`, `dcache_req`, `dcache_hit`  in  1 each  cache strobes.
- `tr_valid`  out  1  trace word valid.
- `tr_ready`  in  1  consumer accepts word.
- `tr_data`  out  16  trace word.
- `tr_last`  out  1  last word of a record.
- `overflow`  out  1  sticky; at least one event dropped.
- `done`  out  1  final statistics word accepted.

## Operation
- Event cycle: `reg_write | mem_read | mem_write | halt`, while capture is not frozen. It is captured as one queue entry holding the flags, `write_reg`, `write_data`, `mem_addr`, and the load or store value.
- Queue occupancy `cnt`:
  - A non-halt event is captured only if `cnt < EVQ_DEPTH-1`.
  - A halt event is captured if `cnt < EVQ_DEPTH`.
  - If an event is rejected: drop it, set `overflow`, and increment `drop_cnt`.
  - A simultaneous push and pop in the same cycle leaves `cnt` unchanged.
- Counters, reset to 0, frozen from the cycle after halt capture onward:
  - `cycle_cnt` (32 bits) increments every cycle, including the halt cycle.
  - `inst_cnt` (32 bits) increments when `halt | reg_write | mem_write`.
  - The four 16-bit cache counters increment on their strobe and saturate at 0xFFFF.
  - Cycle N after reset deasserts is counted as N.
- After halt capture, all inputs are ignored until `rst`.
- Record formats (header bits [15:12] = type):
  - REG: `{4'h1, write_reg, 8'h00}`, data → 2 words.
  - LOAD: `16'h2000`, addr, `mem_rdata` → 3 words.
  - STORE: `16'h3000`, addr, `mem_wdata` → 3 words.
  - HALT: `{4'hF, 4'h0, drop_cnt[7:0]}`, then cycle_hi, cycle_lo, inst_hi, inst_lo, dcache_hit, icache_hit, dcache_req, icache_req → 9 words.
- Within one entry, records are emitted in the order REG, then LOAD/STORE, then HALT. If both `mem_read` and `mem_write` are set, only STORE is emitted.
- Serializer FSM states: IDLE → REG_HDR → REG_DAT → MEM_HDR → MEM_ADDR → MEM_DAT → HALT_HDR → STAT(0..7) → DONE.
  - States for absent records are skipped.
  - The entry is popped when its last word is accepted.
  - After the pop, the FSM goes to IDLE, or directly to the next entry's first state if the queue is non-empty.
  - DONE is absorbing until `rst`.

## Timing
- Reset values: `tr_valid`=0, `tr_data`=0, `tr_last`=0, `overflow`=0, `done`=0; queue empty; all counters 0; FSM in IDLE.
- Capture at the rising edge ending cycle N. With the queue previously empty, the first word is valid in cycle N+1.
- With `tr_ready`=1, words are emitted one per cycle with no gaps within or between records.
- `tr_data`, `tr_last`, `tr_valid` are held stable while `tr_valid & !tr_ready`.
- A word transfers on `tr_valid & tr_ready`.
- `tr_last` is high on the data word (REG), the value word (LOAD/STORE), and the icache_req word (HALT).
- `done` rises the cycle after the final word is accepted; `tr_valid` stays 0 thereafter.
- `rst` mid-record: next cycle all state is as at reset and the partial record is abandoned.

## Structure
- Package `trace_pkg`: record type codes, header constants, stat-word index enum, FSM state enum, and the event-entry struct.
- One sub-module, `trace_evq`: synchronous FIFO of `EVQ_DEPTH` entries providing `cnt`, push/pop, and same-cycle push+pop.
- The top level holds the counters, capture logic, and serializer FSM.

## Test plan
- **REG record.** After reset, `reg_write` with r3 = 0x1234 in cycle 1, `tr_ready`=1 → words 0x1300, 0x1234 in cycles 2–3; `tr_last` on 0x1234.
- **Same-cycle REG and STORE.** `reg_write` r1 = 0x00AA plus `mem_write` to 0x0040 with data 0xBEEF in the same cycle → 0x1100, 0x00AA, 0x3000, 0x0040, 0xBEEF, back-to-back.
- **Backpressure.** A LOAD record while `tr_ready` toggles 0/1 every cycle → each word is held stable while stalled; 3 transfers occur over 6 cycles with values unchanged.
- **Overflow.** `EVQ_DEPTH`=8, `tr_ready`=0, reg writes for 10 cycles, then halt → 7 entries captured, 3 dropped, `overflow`=1, halt captured, and the HALT header reads 0xF003 once drained.
- **Halt statistics.** Halt in cycle 20 after 12 counted instructions, 5 dcache_req, 4 dcache_hit → stats 0x0000, 0x0014, 0x0000, 0x000C, 0x0004, icache_hit, 0x0005, icache_req; `done`=1 after the last word.
- **Reset mid-record.** Assert `rst` during MEM_ADDR → `tr_valid`=0 and `cnt`=0 the next cycle, and a new REG event afterward is emitted normally.
